// File: rtl/clockbox_pkg.sv
// rtl/clockbox_pkg.sv - shared types and helpers for the ClockBox elastic pipeline
package clockbox_pkg;

  typedef enum logic [1:0] {STAGE_EMPTY, STAGE_ONE, STAGE_TWO} stage_state_t;

  // Occupancy counter width able to hold 0..2*depth.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// rtl/skid_stage.sv - one elastic register stage with main and skid entries
module skid_stage
  import clockbox_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  input  logic             down_ready
);

  stage_state_t     state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             push, pop;

  assign push      = up_valid && up_ready;
  assign pop       = down_valid && down_ready;
  assign down_data = main_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      STAGE_EMPTY: begin
        if (push) begin
          state_nxt = STAGE_ONE;
          main_nxt  = up_data;
        end
      end
      STAGE_ONE: begin
        if (push && pop) begin
          main_nxt = up_data;
        end else if (push) begin
          state_nxt = STAGE_TWO;
          skid_nxt  = up_data;
        end else if (pop) begin
          state_nxt = STAGE_EMPTY;
        end
      end
      STAGE_TWO: begin
        // up_ready is low here, so only the drain of the skid entry can happen
        if (pop) begin
          state_nxt = STAGE_ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = STAGE_EMPTY;
    endcase
    if (flush) begin
      state_nxt = STAGE_EMPTY;
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
    end
  end

  // Handshake outputs are flopped from the next state so no ready path chains combinationally.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state      <= STAGE_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      up_ready   <= 1'b1;
      down_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      up_ready   <= (state_nxt != STAGE_TWO);
      down_valid <= (state_nxt != STAGE_EMPTY);
    end
  end

endmodule

// File: rtl/skid_pipe.sv
// rtl/skid_pipe.sv - chain of DEPTH skid stages with flush and occupancy count
module skid_pipe
  import clockbox_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];
  logic             push, pop;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign in_ready   = rdy[0];
  assign out_valid  = vld[DEPTH];
  assign out_data   = dat[DEPTH];
  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clock      (clock),
      .reset_L    (reset_L),
      .flush      (flush),
      .up_valid   (vld[k]),
      .up_data    (dat[k]),
      .up_ready   (rdy[k]),
      .down_valid (vld[k+1]),
      .down_data  (dat[k+1]),
      .down_ready (rdy[k+1])
    );
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Tracked at the module boundary: every entry inside is one accepted push not yet popped.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_skid_pipe.sv
// tb/tb_skid_pipe.sv - scoreboard bench for skid_pipe at DEPTH 1, 2 and 3
module tb_skid_pipe;
  import clockbox_pkg::*;

  localparam int         N  = 3;
  localparam logic [7:0] RV = 8'hC3;

  logic clock   = 1'b0;
  logic reset_L = 1'b1;
  always #5 clock = ~clock;

  logic       fl [N], iv [N], ir [N], ov [N], ordy [N];
  logic [7:0] idat [N], od [N];
  logic [3:0] cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = g + 1;
    logic [count_width(D)-1:0] c;
    skid_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) u_dut (
      .clock     (clock),
      .reset_L   (reset_L),
      .flush     (fl[g]),
      .in_valid  (iv[g]),
      .in_data   (idat[g]),
      .in_ready  (ir[g]),
      .out_valid (ov[g]),
      .out_data  (od[g]),
      .out_ready (ordy[g]),
      .count     (c)
    );
    assign cnt[g] = 4'(c);
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;
  int         sel      = 1;
  logic [7:0] sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pipe is an ideal FIFO of accepted words.
  always @(negedge clock) begin
    if (!reset_L) begin
      sbq.delete();
    end else begin
      check("count_model", cnt[sel], sbq.size());
      check("count_cap", (cnt[sel] <= 4'(2 * (sel + 1))), 1);
      if (ov[sel] && ordy[sel]) begin
        n_pops++;
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word at %0t", od[sel], $time);
        end else begin
          check("pop_data", od[sel], sbq.pop_front());
        end
      end
      if (fl[sel]) sbq.delete();
      else if (iv[sel] && ir[sel]) sbq.push_back(idat[sel]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    do begin
      tick();
      iv[sel]   = 1'b0;
      ordy[sel] = 1'b1;
      k++;
    end while ((cnt[sel] != 0 || ov[sel]) && k < 64);
    check("drain_count", cnt[sel], 0);
    check("drain_sb_empty", sbq.size(), 0);
  endtask

  initial begin
    int  sent;
    bit  acc;
    bit  done;
    for (int i = 0; i < N; i++) begin
      fl[i] = 0; iv[i] = 0; ordy[i] = 0; idat[i] = 0;
    end
    #1 reset_L = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_in_ready", ir[i], 1);
      check("rst_out_valid", ov[i], 0);
      check("rst_out_data", od[i], RV);
      check("rst_count", cnt[i], 0);
    end
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;

    // Streaming, DEPTH=2
    sel = 1;
    for (int j = 0; j < 18; j++) begin
      tick();
      iv[1] = (j < 16); idat[1] = 8'(j + 1); ordy[1] = 1'b1;
      @(negedge clock);
      check("stream_ready", ir[1], 1);
      if (j >= 2) begin
        check("stream_valid", ov[1], 1);
        check("stream_data", od[1], j - 1);
      end else begin
        check("stream_latency", ov[1], 0);
      end
      if (j >= 2 && j <= 16) check("stream_count", cnt[1], 2);
    end
    drain();

    // Fill to full, DEPTH=2
    for (int k = 0; k < 4; k++) begin
      tick();
      iv[1] = 1'b1; idat[1] = 8'hA0 + 8'(k); ordy[1] = 1'b0;
      @(negedge clock);
      check("fill_ready_open", ir[1], 1);
    end
    tick();
    idat[1] = 8'hA4;
    @(negedge clock);
    check("full_ready", ir[1], 0);
    check("full_count", cnt[1], 4);
    tick();
    @(negedge clock);
    check("full_hold_ready", ir[1], 0);
    check("full_hold_count", cnt[1], 4);
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      ordy[1] = 1'b1;
      @(negedge clock);
      if (ir[1]) done = 1;
    end
    check("fill_a4_accepted", done, 1);
    tick();
    iv[1] = 1'b0;
    drain();

    // Flush with simultaneous push and pop, DEPTH=2
    for (int k = 0; k < 3; k++) begin
      tick();
      iv[1] = 1'b1; idat[1] = 8'hB0 + 8'(k); ordy[1] = 1'b0;
    end
    tick();
    iv[1] = 1'b0;
    @(negedge clock);
    check("preflush_count", cnt[1], 3);
    tick();
    fl[1] = 1'b1; iv[1] = 1'b1; idat[1] = 8'hEE; ordy[1] = 1'b1;
    tick();
    fl[1] = 1'b0; iv[1] = 1'b0;
    @(negedge clock);
    check("flush_count", cnt[1], 0);
    check("flush_out_valid", ov[1], 0);
    check("flush_in_ready", ir[1], 1);
    check("flush_out_data", od[1], RV);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      check("flush_no_ghost", ov[1], 0);
    end

    // Asynchronous reset mid-stream, DEPTH=2
    for (int k = 0; k < 3; k++) begin
      tick();
      iv[1] = 1'b1; idat[1] = 8'hD0 + 8'(k); ordy[1] = 1'b0;
    end
    tick();
    iv[1] = 1'b0;
    @(negedge clock);
    check("prereset_count", cnt[1], 3);
    #2 reset_L = 1'b0;
    sbq.delete();
    #1;
    check("arst_out_valid", ov[1], 0);
    check("arst_in_ready", ir[1], 1);
    check("arst_count", cnt[1], 0);
    check("arst_out_data", od[1], RV);
    #1 reset_L = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      iv[1] = (j == 0); idat[1] = 8'h5A; ordy[1] = 1'b1;
      @(negedge clock);
      if (j == 2) begin
        check("post_reset_valid", ov[1], 1);
        check("post_reset_data", od[1], 8'h5A);
      end else begin
        check("post_reset_latency", ov[1], 0);
      end
    end
    drain();

    // Random stall, DEPTH=3
    tick();
    sel = 2; n_pops = 0; sent = 0; acc = 0;
    for (int c = 0; c < 10000 && sent < 1000; c++) begin
      tick();
      if (!iv[2] || acc) begin
        iv[2]   = ($urandom_range(0, 1) == 1);
        idat[2] = 8'($urandom);
      end
      ordy[2] = ($urandom_range(0, 1) == 1);
      @(negedge clock);
      acc = iv[2] && ir[2];
      if (acc) sent++;
    end
    check("rand_sent", sent, 1000);
    tick();
    iv[2] = 1'b0;
    drain();
    check("rand_pops", n_pops, 1000);

    // DEPTH=1 edge case
    tick();
    sel = 0;
    iv[0] = 1'b1; idat[0] = 8'h11; ordy[0] = 1'b0;
    @(negedge clock);
    check("d1_first_ready", ir[0], 1);
    tick();
    idat[0] = 8'h22;
    @(negedge clock);
    check("d1_second_ready", ir[0], 1);
    tick();
    iv[0] = 1'b0;
    @(negedge clock);
    check("d1_full_ready", ir[0], 0);
    check("d1_full_count", cnt[0], 2);
    check("d1_head", od[0], 8'h11);
    tick();
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    @(negedge clock);
    check("d1_ready_after_pop", ir[0], 1);
    check("d1_data_after_pop", od[0], 8'h22);
    check("d1_count_after_pop", cnt[0], 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
